// File: rtl/game_timing_pkg.sv
// ============================================================================
// game_timing_pkg
// Shared timing constants and scheduler state encoding for the block game.
// Revision: 1.0
// ============================================================================
`default_nettype none

package game_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Shift periods for a 50 MHz system clock
  localparam int unsigned DEF_LIMIT_0 = 50_000_000;
  localparam int unsigned DEF_LIMIT_1 = 25_000_000;
  localparam int unsigned DEF_LIMIT_2 = 12_500_000;
  localparam int unsigned DEF_LIMIT_3 = 6_250_000;
  localparam int unsigned DEF_CNT_W   = 26;

endpackage

`default_nettype wire

// File: rtl/shift_scheduler_period_counter.sv
// ============================================================================
// period_counter
// Clearable, holdable period counter with a wrap flag at limit-1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module period_counter
  import game_timing_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_m1_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign wrap_o = (cnt_q == limit_m1_i);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_scheduler.sv
// ============================================================================
// shift_scheduler
// Turns the speed code into periodic one-cycle shift pulses with run/hold/step.
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_scheduler
  import game_timing_pkg::*;
#(
  parameter int unsigned LIMIT_0 = DEF_LIMIT_0,
  parameter int unsigned LIMIT_1 = DEF_LIMIT_1,
  parameter int unsigned LIMIT_2 = DEF_LIMIT_2,
  parameter int unsigned LIMIT_3 = DEF_LIMIT_3,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] speed,
  input  logic       run,
  input  logic       step,
  output logic       shift_en,
  output logic [1:0] active_speed,
  output logic       running,
  output logic [7:0] shift_count
);

  localparam logic [CNT_W-1:0] c_LIMIT0_M1 = CNT_W'(LIMIT_0 - 1);
  localparam logic [CNT_W-1:0] c_LIMIT1_M1 = CNT_W'(LIMIT_1 - 1);
  localparam logic [CNT_W-1:0] c_LIMIT2_M1 = CNT_W'(LIMIT_2 - 1);
  localparam logic [CNT_W-1:0] c_LIMIT3_M1 = CNT_W'(LIMIT_3 - 1);

  state_e           state_q, state_d;
  logic             shift_en_q, shift_en_d;
  logic [1:0]       speed_q, speed_d;
  logic             running_q, running_d;
  logic [7:0]       count_q, count_d;

  logic [CNT_W-1:0] limit_m1;
  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             cnt_clr;
  logic             cnt_en;

  // Mux driven from the registered speed keeps raw switch input off this path
  always_comb begin
    unique case (speed_q)
      2'd0:    limit_m1 = c_LIMIT0_M1;
      2'd1:    limit_m1 = c_LIMIT1_M1;
      2'd2:    limit_m1 = c_LIMIT2_M1;
      default: limit_m1 = c_LIMIT3_M1;
    endcase
  end

  period_counter #(
    .CNT_W (CNT_W)
  ) u_period_counter (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .limit_m1_i (limit_m1),
    .cnt_o      (cnt),
    .wrap_o     (wrap)
  );

  always_comb begin
    state_d    = state_q;
    speed_d    = speed_q;
    shift_en_d = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_RUN;
          cnt_clr = 1'b1;
          speed_d = speed;
        end else if (step) begin
          shift_en_d = 1'b1;
          speed_d    = speed;
        end
      end
      ST_RUN: begin
        // Dropping run freezes cnt even on the wrap cycle
        if (!run) begin
          state_d = ST_HOLD;
        end else begin
          cnt_en = 1'b1;
          if (wrap) begin
            shift_en_d = 1'b1;
            speed_d    = speed;
          end
        end
      end
      ST_HOLD: begin
        if (run) begin
          state_d = ST_RUN;
        end else if (step) begin
          shift_en_d = 1'b1;
          cnt_clr    = 1'b1;
          speed_d    = speed;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    running_d = (state_d == ST_RUN);
    count_d   = shift_en_d ? count_q + 8'd1 : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_en_q <= 1'b0;
      speed_q    <= 2'd0;
      running_q  <= 1'b0;
      count_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      shift_en_q <= shift_en_d;
      speed_q    <= speed_d;
      running_q  <= running_d;
      count_q    <= count_d;
    end
  end

  assign shift_en     = shift_en_q;
  assign active_speed = speed_q;
  assign running      = running_q;
  assign shift_count  = count_q;

endmodule

`default_nettype wire
